// File: rtl/spike_count_classifier_if.sv
// Spike-count classifier bus.
//
// Groups the control, sample and result signals of spike_count_classifier.
// The clock and reset are not part of the bus.
//   master : drives start, spikes_in, data_ready_in, window_len, result_ready;
//            observes counts_out, class_out, margin_out, result_valid, busy, dropped
//   slave  : the classifier side (directions reversed)
interface spike_count_classifier_if #(
   parameter int unsigned N     = 8,
   parameter int unsigned CNT_W = 6,
   parameter int unsigned WIN_W = 8,
   parameter int unsigned CLS_W = 3
);
   logic                 start;
   logic [N-1:0]         spikes_in;
   logic                 data_ready_in;
   logic [WIN_W-1:0]     window_len;
   logic                 result_ready;
   logic [N*CNT_W-1:0]   counts_out;
   logic [CLS_W-1:0]     class_out;
   logic [CNT_W-1:0]     margin_out;
   logic                 result_valid;
   logic                 busy;
   logic                 dropped;

   modport master (
      output start, spikes_in, data_ready_in, window_len, result_ready,
      input  counts_out, class_out, margin_out, result_valid, busy, dropped
   );

   modport slave (
      input  start, spikes_in, data_ready_in, window_len, result_ready,
      output counts_out, class_out, margin_out, result_valid, busy, dropped
   );
endinterface

// File: rtl/spike_count_classifier.sv
// Spike-count classifier.
//
// Counts output-layer spikes per neuron over a window of window_len sample
// strobes, then scans the counters one neuron per cycle to find the winner
// (lowest index on ties) and holds the result until the consumer accepts it.
//
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : asynchronous active-low reset
//   bus    : spike_count_classifier_if.slave (start, spikes_in, data_ready_in,
//            window_len, result_ready in; counts_out, class_out, margin_out,
//            result_valid, busy, dropped out)
//
// Build option: define SPIKE_COUNT_CLASSIFIER_MARGIN_EN to track the runner-up
// and report winner-minus-runner-up on margin_out; otherwise margin_out is 0.
module spike_count_classifier #(
   parameter int unsigned N     = 8,
   parameter int unsigned CNT_W = 6,
   parameter int unsigned WIN_W = 8,
   parameter int unsigned CLS_W = 3
) (
   input logic                     clk,
   input logic                     reset,
   spike_count_classifier_if.slave bus
);

   localparam int unsigned      IdxW    = (N > 1) ? $clog2(N) : 1;
   localparam logic [IdxW-1:0]  LastIdx = IdxW'(N - 1);
   localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};

   typedef enum logic [1:0] {StIdle, StAccum, StArgmax, StHold} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q [N];
   logic [CNT_W-1:0]   cnt_d [N];
   logic [WIN_W-1:0]   smp_q, smp_d;
   logic [WIN_W-1:0]   win_len_q, win_len_d;
   logic [IdxW-1:0]    scan_q, scan_d;
   logic [CNT_W-1:0]   best_val_q, best_val_d;
   logic [IdxW-1:0]    best_idx_q, best_idx_d;
   logic [CLS_W-1:0]   class_q, class_d;
   logic               valid_q, valid_d;
   logic               busy_q, busy_d;
   logic               dropped_q, dropped_d;
   logic [CNT_W-1:0]   cur;
   logic [N*CNT_W-1:0] counts_flat;
`ifdef SPIKE_COUNT_CLASSIFIER_MARGIN_EN
   logic [CNT_W-1:0]   sec_val_q, sec_val_d;
   logic [CNT_W-1:0]   margin_q, margin_d;
`endif

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      smp_d      = smp_q;
      win_len_d  = win_len_q;
      scan_d     = scan_q;
      best_val_d = best_val_q;
      best_idx_d = best_idx_q;
      class_d    = class_q;
      valid_d    = valid_q;
      dropped_d  = dropped_q;
      cur        = '0;
`ifdef SPIKE_COUNT_CLASSIFIER_MARGIN_EN
      sec_val_d  = sec_val_q;
      margin_d   = margin_q;
`endif

      // Strobes are only consumed while accumulating.
      if (bus.data_ready_in && (state_q != StAccum)) begin
         dropped_d = 1'b1;
      end

      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               for (int unsigned i = 0; i < N; i++) begin
                  cnt_d[i] = '0;
               end
               dropped_d = 1'b0;
               smp_d     = '0;
               win_len_d = (bus.window_len == '0) ? WIN_W'(1) : bus.window_len;
               state_d   = StAccum;
            end
         end

         StAccum: begin
            if (bus.data_ready_in) begin
               for (int unsigned i = 0; i < N; i++) begin
                  if (bus.spikes_in[i] && (cnt_q[i] != CntMax)) begin
                     cnt_d[i] = cnt_q[i] + CNT_W'(1);
                  end
               end
               smp_d = smp_q + WIN_W'(1);
               if (smp_q == (win_len_q - WIN_W'(1))) begin
                  state_d    = StArgmax;
                  scan_d     = '0;
                  best_val_d = '0;
                  best_idx_d = '0;
`ifdef SPIKE_COUNT_CLASSIFIER_MARGIN_EN
                  sec_val_d  = '0;
`endif
               end
            end
         end

         StArgmax: begin
            cur = cnt_q[scan_q];
            // Strict compare: an equal later count never displaces the winner.
            if (cur > best_val_q) begin
               best_val_d = cur;
               best_idx_d = scan_q;
`ifdef SPIKE_COUNT_CLASSIFIER_MARGIN_EN
               sec_val_d  = best_val_q;
            end else if (cur > sec_val_q) begin
               sec_val_d  = cur;
`endif
            end
            if (scan_q == LastIdx) begin
               state_d = StHold;
            end else begin
               scan_d = scan_q + IdxW'(1);
            end
         end

         StHold: begin
            // First HOLD cycle publishes the scan result; the handshake is
            // only honoured once result_valid is visible.
            if (!valid_q) begin
               valid_d  = 1'b1;
               class_d  = CLS_W'(best_idx_q);
`ifdef SPIKE_COUNT_CLASSIFIER_MARGIN_EN
               margin_d = best_val_q - sec_val_q;
`endif
            end else if (bus.result_ready) begin
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end
      endcase

      busy_d = (state_d == StAccum) || (state_d == StArgmax);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= StIdle;
         for (int unsigned i = 0; i < N; i++) begin
            cnt_q[i] <= '0;
         end
         smp_q      <= '0;
         win_len_q  <= WIN_W'(1);
         scan_q     <= '0;
         best_val_q <= '0;
         best_idx_q <= '0;
         class_q    <= '0;
         valid_q    <= 1'b0;
         busy_q     <= 1'b0;
         dropped_q  <= 1'b0;
`ifdef SPIKE_COUNT_CLASSIFIER_MARGIN_EN
         sec_val_q  <= '0;
         margin_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         smp_q      <= smp_d;
         win_len_q  <= win_len_d;
         scan_q     <= scan_d;
         best_val_q <= best_val_d;
         best_idx_q <= best_idx_d;
         class_q    <= class_d;
         valid_q    <= valid_d;
         busy_q     <= busy_d;
         dropped_q  <= dropped_d;
`ifdef SPIKE_COUNT_CLASSIFIER_MARGIN_EN
         sec_val_q  <= sec_val_d;
         margin_q   <= margin_d;
`endif
      end
   end

   always_comb begin
      counts_flat = '0;
      for (int unsigned i = 0; i < N; i++) begin
         counts_flat[i*CNT_W +: CNT_W] = cnt_q[i];
      end
   end

   assign bus.counts_out   = counts_flat;
   assign bus.class_out    = class_q;
   assign bus.result_valid = valid_q;
   assign bus.busy         = busy_q;
   assign bus.dropped      = dropped_q;
`ifdef SPIKE_COUNT_CLASSIFIER_MARGIN_EN
   assign bus.margin_out   = margin_q;
`else
   assign bus.margin_out   = '0;
`endif

endmodule

// File: tb/tb_spike_count_classifier.sv
// Testbench for spike_count_classifier: directed windows, scoreboard queue of
// expected results, separate monitor that checks each new result.
module tb_spike_count_classifier;

   localparam int unsigned N     = 8;
   localparam int unsigned CNT_W = 6;
   localparam int unsigned WIN_W = 8;
   localparam int unsigned CLS_W = 3;

   typedef struct {
      logic [CLS_W-1:0]   cls;
      logic [CNT_W-1:0]   mrg;
      logic [N*CNT_W-1:0] cnts;
      int unsigned        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   int unsigned cyc = 0;
   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   logic        valid_prev = 1'b0;

   spike_count_classifier_if #(.N(N), .CNT_W(CNT_W), .WIN_W(WIN_W), .CLS_W(CLS_W)) bus ();

   spike_count_classifier #(.N(N), .CNT_W(CNT_W), .WIN_W(WIN_W), .CLS_W(CLS_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [CNT_W-1:0] mexp(input int unsigned m);
`ifdef SPIKE_COUNT_CLASSIFIER_MARGIN_EN
      return CNT_W'(m);
`else
      return CNT_W'(m * 0);
`endif
   endfunction

   function automatic logic [N*CNT_W-1:0] cnt_model(input logic [N-1:0] pat,
                                                    input int unsigned nstr);
      logic [N*CNT_W-1:0] r;
      int unsigned        sat;
      r   = '0;
      sat = (nstr > 63) ? 63 : nstr;
      for (int i = 0; i < N; i++) begin
         if (pat[i]) r[i*CNT_W +: CNT_W] = CNT_W'(sat);
      end
      return r;
   endfunction

   // Monitor: every rising result_valid must match the oldest expectation.
   always @(negedge clk) begin
      if (bus.result_valid && !valid_prev) begin
         check("result_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("class_out", 64'(bus.class_out), 64'(mon_e.cls));
            check("margin_out", 64'(bus.margin_out), 64'(mon_e.mrg));
            check("counts_out", 64'(bus.counts_out), 64'(mon_e.cnts));
            check("latency", 64'(cyc - mon_e.last), 64'(N + 1));
         end
      end
      valid_prev <= bus.result_valid;
   end

   // Runs one window of nstr strobes of pattern pat, with an idle gap after
   // every second strobe; optionally pulses start mid-window.
   task automatic run_window(input int unsigned wlen, input int unsigned nstr,
                             input logic [N-1:0] pat, input int unsigned cls,
                             input int unsigned mrg, input bit mid_start);
      exp_t e;
      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.window_len = WIN_W'(wlen);
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("busy_accum", 64'(bus.busy), 64'd1);
      for (int k = 0; k < nstr; k++) begin
         bus.spikes_in     = pat;
         bus.data_ready_in = 1'b1;
         if (mid_start && k == 1) bus.start = 1'b1;
         @(posedge clk); #1;
         bus.data_ready_in = 1'b0;
         bus.spikes_in     = '0;
         bus.start         = 1'b0;
         if (k % 2 == 1 && k != nstr - 1) begin
            @(posedge clk); #1;
         end
      end
      e.cls  = CLS_W'(cls);
      e.mrg  = mexp(mrg);
      e.cnts = cnt_model(pat, nstr);
      e.last = cyc;
      sb.push_back(e);
      for (int w = 0; w < 60 && sb.size() != 0; w++) @(negedge clk);
      check("result_timeout", 64'(sb.size()), 64'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      bus.start         = 1'b0;
      bus.spikes_in     = '0;
      bus.data_ready_in = 1'b0;
      bus.window_len    = '0;
      bus.result_ready  = 1'b1;

      // Reset state.
      #12;
      check("rst_counts", 64'(bus.counts_out), 64'd0);
      check("rst_class", 64'(bus.class_out), 64'd0);
      check("rst_margin", 64'(bus.margin_out), 64'd0);
      check("rst_valid", 64'(bus.result_valid), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_dropped", 64'(bus.dropped), 64'd0);
      reset = 1'b1;

      // Single active neuron.
      run_window(4, 4, 8'b0000_0100, 2, 4, 1'b0);
      // Saturation: all neurons equal at 63.
      run_window(70, 70, 8'hFF, 0, 0, 1'b0);
      // Tie between neurons 1 and 5; start mid-window must be ignored.
      run_window(3, 3, 8'b0010_0010, 1, 0, 1'b1);
      // window_len 0 behaves as a one-strobe window.
      run_window(0, 1, 8'b0000_1000, 3, 1, 1'b0);

      // Held result with back-pressure.
      bus.result_ready = 1'b0;
      run_window(2, 2, 8'b1000_0000, 7, 2, 1'b0);
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check("hold_valid", 64'(bus.result_valid), 64'd1);
         check("hold_class", 64'(bus.class_out), 64'd7);
         check("hold_margin", 64'(bus.margin_out), 64'(mexp(2)));
         check("hold_counts", 64'(bus.counts_out), 64'(cnt_model(8'b1000_0000, 2)));
      end
      bus.result_ready = 1'b1;
      bus.start        = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("handshake_valid", 64'(bus.result_valid), 64'd0);
      check("hold_start_ignored", 64'(bus.busy), 64'd0);
      bus.spikes_in     = 8'hFF;
      bus.data_ready_in = 1'b1;
      @(posedge clk); #1;
      bus.data_ready_in = 1'b0;
      bus.spikes_in     = '0;
      check("idle_strobe_dropped", 64'(bus.dropped), 64'd1);
      check("idle_strobe_counts", 64'(bus.counts_out), 64'(cnt_model(8'b1000_0000, 2)));

      // Reset in the middle of a window.
      @(posedge clk); #1;
      bus.start      = 1'b1;
      bus.window_len = 8'd4;
      @(posedge clk); #1;
      bus.start = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus.spikes_in     = 8'b0000_0011;
         bus.data_ready_in = 1'b1;
         @(posedge clk); #1;
      end
      bus.data_ready_in = 1'b0;
      #2;
      reset = 1'b0;
      #1;
      check("midrst_counts", 64'(bus.counts_out), 64'd0);
      check("midrst_class", 64'(bus.class_out), 64'd0);
      check("midrst_valid", 64'(bus.result_valid), 64'd0);
      check("midrst_busy", 64'(bus.busy), 64'd0);
      check("midrst_dropped", 64'(bus.dropped), 64'd0);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      for (int k = 0; k < 2; k++) begin
         bus.data_ready_in = 1'b1;
         @(posedge clk); #1;
      end
      bus.data_ready_in = 1'b0;
      bus.spikes_in     = '0;
      repeat (N + 6) @(posedge clk);
      #1;
      check("post_rst_valid", 64'(bus.result_valid), 64'd0);
      check("post_rst_busy", 64'(bus.busy), 64'd0);
      check("post_rst_dropped", 64'(bus.dropped), 64'd1);
      check("post_rst_counts", 64'(bus.counts_out), 64'd0);

      check("scoreboard_empty", 64'(sb.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/spike_count_classifier.md
SPIKE_COUNT_CLASSIFIER -- requirements
Module: spike_count_classifier

Interface
REQ-001 SHALL have parameter N, default 8, number of output-layer neurons observed.
REQ-002 SHALL have parameter CNT_W, default 6, per-neuron spike counter width.
REQ-003 SHALL have parameter WIN_W, default 8, window-length field width.
REQ-004 SHALL have parameter CLS_W, default 3, class index width (CLS_W >= clog2(N)).
REQ-005 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-007 SHALL have port start  input  1  one-cycle pulse: clear counters, open a window.
REQ-008 SHALL have port spikes_in  input  N  output-layer spike vector from the two-layer network.
REQ-009 SHALL have port data_ready_in  input  1  sample strobe; spikes_in valid when 1.
REQ-010 SHALL have port window_len  input  WIN_W  strobes per window; sampled on start.
REQ-011 SHALL have port result_ready  input  1  consumer accepts the result.
REQ-012 SHALL have port counts_out  output  N*CNT_W  live counters, neuron i at bits [i*CNT_W +: CNT_W].
REQ-013 SHALL have port class_out  output  CLS_W  winning neuron index.
REQ-014 SHALL have port margin_out  output  CNT_W  winner count minus runner-up count.
REQ-015 SHALL have port result_valid  output  1  class_out/margin_out valid.
REQ-016 SHALL have port busy  output  1  high in ACCUM or ARGMAX.
REQ-017 SHALL have port dropped  output  1  sticky: strobe arrived outside ACCUM since last start.

Function
REQ-018 SHALL implement FSM IDLE, ACCUM, ARGMAX, HOLD; all outputs registered.
REQ-019 IDLE: start=1 -> clear counters, dropped, sample counter; latch window_len (0 treated as 1); go ACCUM.
REQ-020 ACCUM: each data_ready_in=1 cycle adds spikes_in[i] to counter i, saturating at 2^CNT_W-1, increments sample counter.
REQ-021 ACCUM: edge sampling the window_len-th strobe counts that strobe then goes ARGMAX.
REQ-022 ARGMAX: scan one neuron per cycle, index 0..N-1, strict greater-than compare; ties keep lowest index; runner-up tracked with same scan.
REQ-023 After N ARGMAX cycles go HOLD; result_valid rises exactly N+1 edges after the final-strobe edge.
REQ-024 HOLD: class_out, margin_out, counts_out stable; result_valid=1 until result_ready=1 sampled, then IDLE, result_valid=0 next cycle.
REQ-025 start outside IDLE SHALL be ignored; start and result_ready together in HOLD -> handshake completes, start ignored.
REQ-026 data_ready_in=1 in IDLE, ARGMAX or HOLD SHALL not change counters and SHALL set dropped.
REQ-027 margin SHALL be 0 when winner and runner-up counts are equal, including all-zero counts (class_out=0).

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, counters 0, class_out 0, margin_out 0, result_valid 0, busy 0, dropped 0.
REQ-029 reset mid-ACCUM or mid-ARGMAX SHALL abandon the window; no result produced after release.

Configuration
REQ-030 Macro SPIKE_COUNT_CLASSIFIER_MARGIN_EN defined: runner-up tracking and margin_out computed per REQ-022/027.
REQ-031 Macro undefined: runner-up logic omitted, margin_out tied to 0; class_out and timing unchanged.

Verification
REQ-032 window_len=4, 4 strobes with spikes_in=8'b0000_0100 -> counts[2]=4, others 0, class_out=2, margin_out=4, result_valid at edge N+1=9 after last strobe.
REQ-033 window_len=70, spikes_in=8'hFF every strobe -> all counters saturate at 63, class_out=0, margin_out=0.
REQ-034 Tie: counts[5]=3, counts[1]=3, others 0 -> class_out=1, margin_out=0.
REQ-035 result_ready held 0 for 20 cycles in HOLD -> outputs stable, result_valid=1; result_ready=1 -> IDLE, result_valid=0 next cycle; strobe then -> dropped=1.
REQ-036 reset=0 pulse during ACCUM after 2 of 4 strobes -> all outputs 0, IDLE; no result_valid until a new start.
REQ-037 Build without SPIKE_COUNT_CLASSIFIER_MARGIN_EN, rerun REQ-032 -> class_out=2, margin_out=0, same latency.
